ps2_host_tx: RTL



---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_line_sync.sv | 42 ++++
 rtl/ps2_host_tx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 host transmitter:
//                transmitter state encoding, frame edge indices and the
//                common keyboard command/response bytes.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        RTS     = 3'd2,
        SHIFT   = 3'd3,
        RELEASE = 3'd4,
        FAIL    = 3'd5
    } ps2_tx_state_e;

    // Device falling edges in one host-to-device frame, and the edge numbers
    // at which the parity bit, stop bit and ACK sample happen.
    localparam int FRAME_EDGES = 11;
    localparam int EDGE_PARITY = 9;
    localparam int EDGE_STOP   = 10;
    localparam int EDGE_ACK    = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // PS/2 uses odd parity: the parity bit makes the count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_sync
//  Description : Two-flop synchroniser for one raw PS/2 line plus falling
//                edge detection on the synchronised level. All flops reset
//                to 1, the idle (released) level of an open-drain line.
//  Ports       : clk     - system clock
//                reset   - synchronous, active-high
//                line_i  - raw asynchronous pin level
//                level_o - synchronised level
//                fall_o  - one-cycle pulse: synced level went 1 -> 0
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//                request-to-send, shifts one command byte out on the device
//                generated clock and checks the device ACK. Lines are driven
//                as open-drain pull-down enables.
//  Options     : PS2_TX_RETRY_EN - when defined, a NACK or timeout restarts
//                the frame up to MAX_RETRY more times before tx_err.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                tx_data/tx_valid    - command byte and request
//                tx_ready            - high in IDLE only
//                tx_done / tx_err    - one-cycle completion pulses
//                tx_nack             - cause of last tx_err (1 NACK, 0 timeout)
//                rx_block            - busy, receiver must ignore the bus
//                ps2clk_in/ps2data_in   - raw pin levels
//                ps2clk_oe/ps2data_oe   - 1 = pull line low
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       tx_nack,
    output logic       rx_block,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);
    import ps2_pkg::*;

    // One counter serves both the inhibit delay and the device timeout.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EDGE_W  = $clog2(FRAME_EDGES + 1);

    localparam logic [CNT_W-1:0]  INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [EDGE_W-1:0] E_LAST_DATA = EDGE_W'(8);
    localparam logic [EDGE_W-1:0] E_PAR    = EDGE_W'(EDGE_PARITY);
    localparam logic [EDGE_W-1:0] E_STOP   = EDGE_W'(EDGE_STOP);

    logic clk_sync, clk_fall;
    logic data_sync, data_fall;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2clk_in),
        .level_o (clk_sync),
        .fall_o  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2data_in),
        .level_o (data_sync),
        .fall_o  (data_fall)
    );

    // Only the level of the data line matters to the transmitter.
    logic w_unused;
    assign w_unused = data_fall & (MAX_RETRY != 0);

    ps2_tx_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [EDGE_W-1:0] edge_next;
    logic [7:0]        data_q, data_d;
    logic              par_q, par_d;
    logic              clk_oe_q, clk_oe_d;
    logic              data_oe_q, data_oe_d;
    logic              nack_q, nack_d;
    logic              fail, fail_nack;
    logic              done, err;

`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_q, retry_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            nack_q     <= nack_d;
        end
    end

    assign edge_next = edge_cnt_q + EDGE_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        data_d     = data_q;
        par_d      = par_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        nack_d     = nack_q;
        fail       = 1'b0;
        fail_nack  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d    = retry_q;
`endif

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    data_d   = tx_data;
                    par_d    = odd_parity(tx_data);
                    nack_d   = 1'b0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d  = '0;
`endif
                end
            end

            INHIBIT: begin
                clk_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;       // start bit
                    state_d   = RTS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Start bit and inhibit overlap for one cycle before the clock
            // is handed to the device.
            RTS: begin
                clk_oe_d   = 1'b0;
                edge_cnt_d = '0;
                cnt_d      = '0;
                state_d    = SHIFT;
            end

            SHIFT: begin
                if (clk_fall) begin
                    cnt_d      = '0;
                    edge_cnt_d = edge_next;
                    if (edge_next <= E_LAST_DATA) begin
                        data_oe_d = ~data_q[edge_cnt_q[2:0]];
                    end else if (edge_next == E_PAR) begin
                        data_oe_d = ~par_q;
                    end else if (edge_next == E_STOP) begin
                        data_oe_d = 1'b0;
                    end else if (data_sync) begin
                        fail      = 1'b1;   // device left data high: NACK
                        fail_nack = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (clk_sync && data_sync) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FAIL: begin
                err       = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        if (fail) begin
            nack_d    = fail_nack;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
                retry_d  = retry_q + RETRY_W'(1);
                cnt_d    = '0;
                clk_oe_d = 1'b1;
                state_d  = INHIBIT;
            end else begin
                state_d = FAIL;
            end
`else
            state_d = FAIL;
`endif
        end
    end

    assign tx_ready   = (state_q == IDLE);
    assign rx_block   = (state_q != IDLE);
    assign tx_done    = done;
    assign tx_err     = err;
    assign tx_nack    = nack_q;
    assign ps2clk_oe  = clk_oe_q;
    assign ps2data_oe = data_oe_q;

endmodule
`default_nettype wire
